// File: rtl/ext_mem_arbiter_if.sv
// ext_mem_arbiter_if: one requester port of the external memory burst arbiter.
// The arbiter takes the slave modport; a refill/writeback requester takes master.
interface ext_mem_arbiter_if #(
  parameter int LW = 3
);
  logic          req;
  logic          we;
  logic [29:0]   addr;
  logic [LW-1:0] len;
  logic [31:0]   wdata;
  logic          ack;
  logic          wready;
  logic          rvalid;
  logic          done;
  modport slave  (input req, we, addr, len, wdata, output ack, wready, rvalid, done);
  modport master (output req, we, addr, len, wdata, input ack, wready, rvalid, done);
endinterface

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: two-port burst controller/arbiter for the multiplexed 32-bit external memory bus.
// Define EXTMEM_RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module ext_mem_arbiter #(
  parameter int WAIT_CYCLES = 4,
  parameter int MAX_BURST   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ext_mem_arbiter_if.slave p0,
  ext_mem_arbiter_if.slave p1,
  output logic [31:0]      rdata,
  output logic             en,
  inout  wire  [31:0]      bus
);
  localparam int LW = $clog2(MAX_BURST);
  localparam int TW = $clog2(WAIT_CYCLES + 2) + 1;
  typedef enum logic [2:0] {BLANK, IDLE, ADDR, WAIT, XFER, END} state_e;
  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [LW-1:0] wcnt_q, wcnt_d, len_q, len_d;
  logic [29:0]   addr_q, addr_d;
  logic          gnt_q, gnt_d, we_q, we_d;
  logic          pick, drv, rv;
`ifdef EXTMEM_RR_ARB_EN
  logic ptr_q, ptr_d;
  assign ptr_d = (state_q == IDLE && p0.req && p1.req) ? ~ptr_q : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  assign pick = (p0.req && p1.req) ? ptr_q : p1.req;
`else
  assign pick = ~p0.req;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= BLANK;
      tmr_q   <= '0;
      wcnt_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
    end
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    wcnt_d  = wcnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    case (state_q)
      BLANK: begin
        tmr_d   = tmr_q + 1'b1;
        state_d = (tmr_q == TW'(WAIT_CYCLES + 1)) ? IDLE : BLANK;
      end
      IDLE: if (p0.req || p1.req) begin
        gnt_d   = pick;
        we_d    = pick ? p1.we : p0.we;
        addr_d  = pick ? p1.addr : p0.addr;
        len_d   = pick ? p1.len : p0.len;
        state_d = ADDR;
      end
      ADDR: begin
        tmr_d   = '0;
        wcnt_d  = '0;
        state_d = (WAIT_CYCLES == 0) ? XFER : WAIT;
      end
      WAIT: begin
        tmr_d   = tmr_q + 1'b1;
        state_d = (tmr_q == TW'(WAIT_CYCLES - 1)) ? XFER : WAIT;
      end
      XFER: begin
        wcnt_d  = wcnt_q + 1'b1;
        state_d = (wcnt_q == len_q) ? END : XFER;
      end
      default: state_d = IDLE;
    endcase
  end
  // memory registers read data, so word k lands one cycle after its en-cycle, the last one in END
  assign rv    = ~we_q && ((state_q == XFER && wcnt_q != '0) || state_q == END);
  assign drv   = state_q == ADDR || (state_q == XFER && we_q);
  assign bus   = drv ? (state_q == ADDR ? {we_q, 1'b0, addr_q} : (gnt_q ? p1.wdata : p0.wdata)) : 'z;
  assign rdata = bus;
  assign en    = state_q == ADDR || state_q == WAIT || state_q == XFER;
  assign p0.ack    = state_q == ADDR && !gnt_q;
  assign p1.ack    = state_q == ADDR && gnt_q;
  assign p0.wready = state_q == XFER && we_q && !gnt_q;
  assign p1.wready = state_q == XFER && we_q && gnt_q;
  assign p0.rvalid = rv && !gnt_q;
  assign p1.rvalid = rv && gnt_q;
  assign p0.done   = state_q == END && !gnt_q;
  assign p1.done   = state_q == END && gnt_q;
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: scoreboard bench for ext_mem_arbiter against a behavioural external memory.
module tb_ext_mem_arbiter;
  localparam int W  = 4;
  localparam int LW = 3;
`ifdef EXTMEM_RR_ARB_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif
  typedef struct {int port; logic [31:0] abus;} gnt_t;
  typedef struct {int port; logic [31:0] data; int rel;} rd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] rdata;
  logic en;
  wire  [31:0] bus;
  int total = 0, bad = 0, cyc = 0, t_ack = 0, done_cnt = 0;
  int wr_cnt = 0, wr_first = 0, wr_last = 0;
  gnt_t gq[$];
  rd_t  rq[$];
  gnt_t mg;
  rd_t  mr;
  ext_mem_arbiter_if #(.LW(LW)) p0_if ();
  ext_mem_arbiter_if #(.LW(LW)) p1_if ();
  ext_mem_arbiter #(.WAIT_CYCLES(W), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .p0(p0_if), .p1(p1_if), .rdata(rdata), .en(en), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // external memory: address cycle, W dead cycles, then one word per en-cycle, read data registered
  logic [31:0] mem [0:1023];
  logic [31:0] mq = '0;
  logic        moe = 1'b0, mwe = 1'b0;
  logic [29:0] maddr = '0;
  int          mph = 0, mk = 0;
  assign bus = moe ? mq : 'z;
  always @(posedge clk) begin
    if (!en) begin mph <= 0; moe <= 1'b0; end
    else if (mph == 0) begin mwe <= bus[31]; maddr <= bus[29:0]; mk <= 0; mph <= 1; moe <= 1'b0; end
    else if (mph <= W) begin mph <= mph + 1; moe <= 1'b0; end
    else begin
      if (mwe) mem[10'(maddr + 30'(mk))] = bus;
      else mq <= mem[10'(maddr + 30'(mk))];
      moe <= !mwe;
      mk  <= mk + 1;
    end
  end
  // requester write-data feeders: restart at ack, advance after each consumed word
  logic [31:0] wb0 = '0, wb1 = '0;
  int wi0 = 0, wi1 = 0;
  logic k0, k1, a0, a1;
  initial forever begin
    @(negedge clk);
    k0 = p0_if.ack; k1 = p1_if.ack; a0 = p0_if.wready; a1 = p1_if.wready;
    @(posedge clk);
    #1;
    wi0 = k0 ? 0 : wi0 + (a0 ? 1 : 0);
    wi1 = k1 ? 0 : wi1 + (a1 ? 1 : 0);
    p0_if.wdata = wb0 + 32'(wi0);
    p1_if.wdata = wb1 + 32'(wi1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (p0_if.ack || p1_if.ack) begin
      t_ack  = cyc;
      wr_cnt = 0;
      chk("gq_nonempty", 32'(gq.size() != 0), 1);
      if (gq.size() != 0) begin
        mg = gq.pop_front();
        chk("gnt_port", 32'(p1_if.ack), mg.port);
        chk("addr_bus", bus, mg.abus);
      end
    end
    if (p0_if.rvalid || p1_if.rvalid) begin
      chk("rq_nonempty", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        mr = rq.pop_front();
        chk("rv_port", 32'(p1_if.rvalid), mr.port);
        chk("rdata", rdata, mr.data);
        chk("rv_time", cyc - t_ack, mr.rel);
      end
    end
    if (p0_if.wready || p1_if.wready) begin
      if (wr_cnt == 0) wr_first = cyc - t_ack;
      wr_last = cyc - t_ack;
      wr_cnt++;
    end
    if (p0_if.done || p1_if.done) done_cnt++;
  end
  task automatic push_read(input int p, input logic [29:0] a, input int l);
    gq.push_back('{p, {2'b00, a}});
    for (int k = 0; k <= l; k++) rq.push_back('{p, mem[10'(a + 30'(k))], W + 2 + k});
  endtask
  task automatic start(input int p, input logic we, input logic [29:0] a, input int l, input logic [31:0] wb);
    if (p == 1) begin
      p1_if.we = we; p1_if.addr = a; p1_if.len = LW'(l); wb1 = wb; p1_if.req = 1'b1;
    end else begin
      p0_if.we = we; p0_if.addr = a; p0_if.len = LW'(l); wb0 = wb; p0_if.req = 1'b1;
    end
  endtask
  task automatic wait_ack(input int p);
    int n = 0;
    while (!(p == 1 ? p1_if.ack : p0_if.ack) && n < 200) begin @(negedge clk); n++; end
    chk("ack_timeout", 32'(n < 200), 1);
    if (p == 1) p1_if.req = 1'b0;
    else p0_if.req = 1'b0;
  endtask
  task automatic wait_done(input int exp_t);
    int n = 0;
    while (!(p0_if.done || p1_if.done) && n < 200) begin @(negedge clk); n++; end
    chk("done_timeout", 32'(n < 200), 1);
    chk("done_time", cyc - t_ack, exp_t);
  endtask
  initial begin
    int n, prev, dsnap;
    logic enh;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, prev, dsnap;
    logic enh;
    p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.len = '0;
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.len = '0;
    for (int i = 0; i < 16; i++) mem[10'h100 + i] = 32'hA0 + 32'(i);
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(en), 0);
    chk("rst_ack0", 32'(p0_if.ack), 0);
    chk("rst_ack1", 32'(p1_if.ack), 0);
    chk("rst_rvalid0", 32'(p0_if.rvalid), 0);
    chk("rst_wready1", 32'(p1_if.wready), 0);
    chk("rst_done0", 32'(p0_if.done), 0);
    // request present at reset release: 6 BLANK cycles plus one IDLE before ADDR
    push_read(0, 30'h100, 3);
    start(0, 1'b0, 30'h100, 3, '0);
    rst_n = 1'b1;
    n = 0; enh = 1'b0;
    while (!p0_if.ack && n < 50) begin enh |= en; @(negedge clk); n++; end
    chk("blank_len", n, 7);
    chk("blank_en", 32'(enh), 0);
    p0_if.req = 1'b0;
    wait_done(9);
    push_write(1, 30'h200);
    start(1, 1'b1, 30'h200, 7, 32'hB0);
    wait_ack(1);
    wait_done(13);
    chk("wr_cnt", wr_cnt, 8);
    chk("wr_first", wr_first, 5);
    chk("wr_last", wr_last, 12);
    for (int k = 0; k < 8; k++) chk("wmem", mem[10'h200 + k], 32'hB0 + 32'(k));
    push_read(0, 30'h100, 0);
    push_read(RR, RR == 1 ? 30'h104 : 30'h100, 0);
    push_read(0, 30'h100, 0);
    start(0, 1'b0, 30'h100, 0, '0);
    start(1, 1'b0, 30'h104, 0, '0);
    prev = 0;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (!(p0_if.ack || p1_if.ack) && n < 200) begin @(negedge clk); n++; end
      chk("arb_ack_timeout", 32'(n < 200), 1);
      if (g > 0) chk("arb_gap", cyc - prev, 8);
      prev = cyc;
      if (g == 2) begin p0_if.req = 1'b0; p1_if.req = 1'b0; end
      wait_done(6);
    end
    push_read(1, 30'h10F, 0);
    start(1, 1'b0, 30'h10F, 0, '0);
    wait_ack(1);
    wait_done(6);
    push_read(0, 30'h100, 7);
    start(0, 1'b0, 30'h100, 7, '0);
    wait_ack(0);
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_en", 32'(en), 0);
    chk("midrst_rvalid", 32'(p0_if.rvalid), 0);
    chk("midrst_done", 32'(p0_if.done), 0);
    dsnap = done_cnt;
    repeat (3) @(negedge clk);
    rq.delete();
    rst_n = 1'b1;
    push_read(0, 30'h108, 3);
    start(0, 1'b0, 30'h108, 3, '0);
    wait_ack(0);
    chk("midrst_no_done", done_cnt, dsnap);
    wait_done(9);
    repeat (3) @(negedge clk);
    chk("rq_drained", rq.size(), 0);
    chk("gq_drained", gq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  task automatic push_write(input int p, input logic [29:0] a);
    gq.push_back('{p, {2'b10, a}});
  endtask
endmodule
